// File: rtl/rv_alu_arb.sv
// rtl/rv_alu_arb.sv - two-port arbiter and 2-stage issue sequencer for the shared ALU
// Optional macro ALU_ARB_RR_EN: round-robin on ties; otherwise port 0 has fixed priority.
module rv_alu_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            resp0_valid,
  output logic [XLEN-1:0] resp0_result,
  output logic            resp0_zero,
  output logic            resp0_err,
  output logic            resp1_valid,
  output logic [XLEN-1:0] resp1_result,
  output logic            resp1_zero,
  output logic            resp1_err
);

  localparam logic [3:0] OP_ADD = 4'b0010;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
      default:                                               op_legal = 1'b0;
    endcase
  endfunction

  logic grant0, grant1, prio0, accept;

`ifdef ALU_ARB_RR_EN
  // last_grant_q = 1 means port 1 was granted last, so port 0 wins the next tie
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0)      last_grant_d = 1'b0;
    else if (grant1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

  assign prio0 = last_grant_q;
`else
  assign prio0 = 1'b1;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && (!req1_valid || prio0)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Stage 1: operand/opcode registers feeding the ALU
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic            s1_valid_q, s1_valid_d, s1_port_q, s1_port_d, s1_err_q, s1_err_d;
  logic [3:0]      sel_op;

  always_comb begin
    sel_op     = grant1 ? req1_op : req0_op;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    s1_valid_d = 1'b0;
    s1_port_d  = s1_port_q;
    s1_err_d   = s1_err_q;
    if (accept) begin
      alu_op_d   = op_legal(sel_op) ? sel_op : OP_ADD;
      alu_a_d    = grant1 ? req1_a : req0_a;
      alu_b_d    = grant1 ? req1_b : req0_b;
      s1_valid_d = 1'b1;
      s1_port_d  = grant1;
      s1_err_d   = ~op_legal(sel_op);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      s1_valid_q <= s1_valid_d;
      s1_port_q  <= s1_port_d;
      s1_err_q   <= s1_err_d;
    end
  end

  // Stage 2: capture ALU output into the owning port's response registers
  logic            r0_valid_q, r0_valid_d, r0_zero_q, r0_zero_d, r0_err_q, r0_err_d;
  logic            r1_valid_q, r1_valid_d, r1_zero_q, r1_zero_d, r1_err_q, r1_err_d;
  logic [XLEN-1:0] r0_result_q, r0_result_d, r1_result_q, r1_result_d;

  always_comb begin
    r0_valid_d  = s1_valid_q & ~s1_port_q;
    r1_valid_d  = s1_valid_q &  s1_port_q;
    r0_result_d = r0_result_q;
    r0_zero_d   = r0_zero_q;
    r0_err_d    = r0_err_q;
    r1_result_d = r1_result_q;
    r1_zero_d   = r1_zero_q;
    r1_err_d    = r1_err_q;
    if (r0_valid_d) begin
      r0_result_d = alu_result;
      r0_zero_d   = alu_zero;
      r0_err_d    = s1_err_q;
    end
    if (r1_valid_d) begin
      r1_result_d = alu_result;
      r1_zero_d   = alu_zero;
      r1_err_d    = s1_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_valid_q  <= 1'b0;
      r0_result_q <= '0;
      r0_zero_q   <= 1'b0;
      r0_err_q    <= 1'b0;
      r1_valid_q  <= 1'b0;
      r1_result_q <= '0;
      r1_zero_q   <= 1'b0;
      r1_err_q    <= 1'b0;
    end else begin
      r0_valid_q  <= r0_valid_d;
      r0_result_q <= r0_result_d;
      r0_zero_q   <= r0_zero_d;
      r0_err_q    <= r0_err_d;
      r1_valid_q  <= r1_valid_d;
      r1_result_q <= r1_result_d;
      r1_zero_q   <= r1_zero_d;
      r1_err_q    <= r1_err_d;
    end
  end

  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign resp0_valid  = r0_valid_q;
  assign resp0_result = r0_result_q;
  assign resp0_zero   = r0_zero_q;
  assign resp0_err    = r0_err_q;
  assign resp1_valid  = r1_valid_q;
  assign resp1_result = r1_result_q;
  assign resp1_zero   = r1_zero_q;
  assign resp1_err    = r1_err_q;

endmodule

// File: tb/tb_rv_alu_arb.sv
// tb/tb_rv_alu_arb.sv - self-checking bench for rv_alu_arb
// Honours ALU_ARB_RR_EN for tie-break expectations.
module tb_rv_alu_arb;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]      req0_op, req1_op, alu_op;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic            alu_zero;
  logic            resp0_valid, resp0_zero, resp0_err, resp1_valid, resp1_zero, resp1_err;
  logic [XLEN-1:0] resp0_result, resp1_result;

  rv_alu_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero), .resp1_err(resp1_err)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          due;
  } resp_t;

  resp_t       q[$];
  int          cyc = 0;
  int          m_last = 1;
  int          obs_grant;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [31:0] h_res [2] = '{32'd0, 32'd0};
  logic        h_zero[2] = '{1'b0, 1'b0};
  logic        h_err [2] = '{1'b0, 1'b0};

  // One clock cycle: drive, check grants/responses at negedge, update model after posedge
  task automatic cycle(input logic r,
                       input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    int g;
    resp_t e;
    logic ev[2];
    logic [3:0] op;
    rst_n = r;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    g = -1;
    if (r) begin
      if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
        g = (m_last == 1) ? 0 : 1;
`else
        g = 0;
`endif
      end else if (v0) g = 0;
      else if (v1) g = 1;
    end
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    obs_grant = req0_ready ? 0 : (req1_ready ? 1 : -1);
    ev[0] = 1'b0; ev[1] = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.port] = 1'b1;
      h_res[e.port] = e.res; h_zero[e.port] = e.zero; h_err[e.port] = e.err;
    end
    chk("resp0_valid", resp0_valid, ev[0]);
    chk("resp0_result", resp0_result, h_res[0]);
    chk("resp0_zero", resp0_zero, h_zero[0]);
    chk("resp0_err", resp0_err, h_err[0]);
    chk("resp1_valid", resp1_valid, ev[1]);
    chk("resp1_result", resp1_result, h_res[1]);
    chk("resp1_zero", resp1_zero, h_zero[1]);
    chk("resp1_err", resp1_err, h_err[1]);
    @(posedge clk); #1;
    cyc++;
    if (!r) begin
      q.delete();
      m_last = 1;
      for (int i = 0; i < 2; i++) begin h_res[i] = '0; h_zero[i] = 1'b0; h_err[i] = 1'b0; end
      m_op = '0; m_a = '0; m_b = '0;
    end else if (g >= 0) begin
      op     = (g == 1) ? op1 : op0;
      m_a    = (g == 1) ? a1 : a0;
      m_b    = (g == 1) ? b1 : b0;
      m_op   = is_legal(op) ? op : 4'b0010;
      e.port = g;
      e.err  = !is_legal(op);
      e.res  = alu_f(m_op, m_a, m_b);
      e.zero = (e.res == 0);
      e.due  = cyc + 1;
      q.push_back(e);
      m_last = g;
    end
    chk("alu_op", alu_op, m_op);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        zero, err;
  } vec_t;

  vec_t vt[10];
  int   exp_tie[4];
  logic [3:0] ops[8];

  initial begin
    vt[0] = '{0, 4'b0010, 32'd5,        32'd7,   32'd12,         1'b0, 1'b0};
    vt[1] = '{1, 4'b0110, 32'd9,        32'd9,   32'd0,          1'b1, 1'b0};
    vt[2] = '{1, 4'b0111, 32'd3,        32'd4,   32'd1,          1'b0, 1'b0};
    vt[3] = '{0, 4'b0000, 32'hF0,       32'h3C,  32'h30,         1'b0, 1'b0};
    vt[4] = '{0, 4'b0001, 32'hF0,       32'h0F,  32'hFF,         1'b0, 1'b0};
    vt[5] = '{1, 4'b1100, 32'd0,        32'd0,   32'hFFFF_FFFF,  1'b0, 1'b0};
    vt[6] = '{0, 4'b0011, 32'd2,        32'd3,   32'd5,          1'b0, 1'b1};
    vt[7] = '{1, 4'b0111, 32'hFFFF_FFFF, 32'd1,  32'd1,          1'b0, 1'b0};
    vt[8] = '{0, 4'b0110, 32'd3,        32'd5,   32'hFFFF_FFFE,  1'b0, 1'b0};
    vt[9] = '{1, 4'b1111, 32'hFFFF_FFFF, 32'd1,  32'd0,          1'b1, 1'b1};
`ifdef ALU_ARB_RR_EN
    exp_tie = '{0, 1, 0, 1};
`else
    exp_tie = '{0, 0, 0, 0};
`endif
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alu_op", alu_op, 4'd0);
    chk("reset_resp0_valid", resp0_valid, 1'b0);
    chk("reset_resp1_result", resp1_result, 32'd0);
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_ready1", req1_ready, 1'b0);

    // Tie straight out of reset
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 4'b0010, 32'd1, 32'd2, 1'b1, 4'b0110, 32'd8, 32'd3);
      chk("tie_grant", obs_grant, exp_tie[i]);
    end
    idle(); idle();

    // Table of single ops
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vt[i].port == 0, vt[i].op, vt[i].a, vt[i].b,
                  vt[i].port == 1, vt[i].op, vt[i].a, vt[i].b);
      chk("vec_alu_op", alu_op, vt[i].err ? 4'b0010 : vt[i].op);
      idle();
      chk("vec_resp_valid", vt[i].port == 0 ? resp0_valid : resp1_valid, 1'b1);
      chk("vec_other_valid", vt[i].port == 0 ? resp1_valid : resp0_valid, 1'b0);
      chk("vec_result", vt[i].port == 0 ? resp0_result : resp1_result, vt[i].res);
      chk("vec_zero", vt[i].port == 0 ? resp0_zero : resp1_zero, vt[i].zero);
      chk("vec_err", vt[i].port == 0 ? resp0_err : resp1_err, vt[i].err);
    end
    idle();

    // Back-to-back on port 1
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0110, 32'd9, 32'd9);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0111, 32'd3, 32'd4);
    chk("b2b_first_valid", resp1_valid, 1'b1);
    chk("b2b_first_result", resp1_result, 32'd0);
    chk("b2b_first_zero", resp1_zero, 1'b1);
    idle();
    chk("b2b_second_valid", resp1_valid, 1'b1);
    chk("b2b_second_result", resp1_result, 32'd1);
    chk("b2b_second_zero", resp1_zero, 1'b0);
    idle();

    // Reset mid-flight drops the op
    cycle(1'b1, 1'b1, 4'b0000, 32'hFF, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0);
    cycle(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 4'b0010, 32'd1, 32'd1);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_resp0_result", resp0_result, 32'd0);
    chk("rst_resp1_result", resp1_result, 32'd0);
    idle();
    chk("rst_no_resp0", resp0_valid, 1'b0);
    cycle(1'b1, 1'b1, 4'b0001, 32'd6, 32'd1, 1'b1, 4'b0001, 32'd2, 32'd2);
    chk("rst_first_tie", obs_grant, 0);
    idle(); idle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic r, v0, v1;
      logic [31:0] a0, b0, a1, b1;
      r  = ($urandom % 60) != 0;
      v0 = ($urandom % 3) != 0;
      v1 = ($urandom % 3) != 0;
      a0 = ($urandom % 2) ? $urandom : $urandom_range(0, 3);
      b0 = ($urandom % 2) ? $urandom : $urandom_range(0, 3);
      a1 = ($urandom % 2) ? $urandom : $urandom_range(0, 3);
      b1 = ($urandom % 2) ? $urandom : $urandom_range(0, 3);
      cycle(r, v0, ops[$urandom % 8], a0, b0, v1, ops[$urandom % 8], a1, b1);
    end
    idle(); idle(); idle();
    chk("drain_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
